// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the core's data port (master) and a memory responder (slave).
// Request operands flow master->slave, ready/error/load data flow back.
interface data_mem_responder_if;
  logic [31:0] d_addr_i;
  logic [31:0] d_data_i;
  logic        d_rd_i;
  logic        d_wr_i;
  logic [1:0]  d_size_i;
  logic        d_unsigned_i;
  logic [31:0] d_data_o;
  logic        d_ready_o;
  logic        d_err_o;

  modport master (
    output d_addr_i, d_data_i, d_rd_i, d_wr_i, d_size_i, d_unsigned_i,
    input  d_data_o, d_ready_o, d_err_o
  );

  modport slave (
    input  d_addr_i, d_data_i, d_rd_i, d_wr_i, d_size_i, d_unsigned_i,
    output d_data_o, d_ready_o, d_err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte/halfword/word loads and stores against an internal RAM,
// with programmable wait states and a one-cycle ready/error completion pulse.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  data_mem_responder_if.slave   bus
);
  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t          state_reg;
  logic [3:0]      cnt_reg;
  logic [AW-1:0]   addr_reg;
  logic [31:0]     data_reg;
  logic [1:0]      size_reg;
  logic            uns_reg;
  logic            wr_reg;
  logic            d_ready_reg;
  logic            d_err_reg;
  logic [31:0]     d_data_reg;

  logic            req;
  logic            req_err;
  logic            in_idle;
  logic            commit;
  logic [AW-1:0]   cur_addr;
  logic [31:0]     cur_data;
  logic [1:0]      cur_size;
  logic            cur_uns;
  logic            cur_wr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]      lane_we;
  logic [3:0][7:0] wdata;
  logic [3:0][7:0] rd_word;
  logic [31:0]     load_val;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;

  assign req     = bus.d_rd_i | bus.d_wr_i;
  assign req_err = (bus.d_rd_i & bus.d_wr_i)
                 | (bus.d_size_i == 2'b11)
                 | ((bus.d_size_i == 2'b01) & bus.d_addr_i[0])
                 | ((bus.d_size_i == 2'b10) & (bus.d_addr_i[1:0] != 2'b00))
                 | ((bus.d_addr_i >> AW) != 32'd0);

  // With zero wait states the access commits straight from the bus operands.
  assign in_idle  = (state_reg == ST_IDLE);
  assign cur_addr = in_idle ? bus.d_addr_i[AW-1:0] : addr_reg;
  assign cur_data = in_idle ? bus.d_data_i         : data_reg;
  assign cur_size = in_idle ? bus.d_size_i         : size_reg;
  assign cur_uns  = in_idle ? bus.d_unsigned_i     : uns_reg;
  assign cur_wr   = in_idle ? bus.d_wr_i           : wr_reg;
  assign idx      = cur_addr[AW-1:2];

  assign commit = !rst_i &&
                  ((in_idle && req && !req_err && (WAIT_STATES == 0)) ||
                   ((state_reg == ST_WAIT) && (cnt_reg == 4'd0)));

  always_comb begin
    lane_we = 4'b0000;
    wdata   = cur_data;
    case (cur_size)
      2'b00: begin
        lane_we[cur_addr[1:0]] = 1'b1;
        wdata = {4{cur_data[7:0]}};
      end
      2'b01: begin
        lane_we = cur_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{cur_data[15:0]}};
      end
      default: lane_we = 4'b1111;
    endcase
  end

  // One byte-wide RAM per lane so stores only touch the selected lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      always_ff @(posedge clk_i) begin
        if (commit && cur_wr && lane_we[gi]) begin
          mem[idx] <= wdata[gi];
        end
      end
      assign rd_word[gi] = mem[idx];
    end
  endgenerate

  always_comb begin
    sel_byte = rd_word[cur_addr[1:0]];
    sel_half = cur_addr[1] ? rd_word[3:2] : rd_word[1:0];
    case (cur_size)
      2'b00:   load_val = {{24{~cur_uns & sel_byte[7]}}, sel_byte};
      2'b01:   load_val = {{16{~cur_uns & sel_half[15]}}, sel_half};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      addr_reg    <= '0;
      data_reg    <= 32'd0;
      size_reg    <= 2'b00;
      uns_reg     <= 1'b0;
      wr_reg      <= 1'b0;
      d_ready_reg <= 1'b0;
      d_err_reg   <= 1'b0;
      d_data_reg  <= 32'd0;
    end else begin
      if (commit && !cur_wr) begin
        d_data_reg <= load_val;
      end
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            addr_reg <= bus.d_addr_i[AW-1:0];
            data_reg <= bus.d_data_i;
            size_reg <= bus.d_size_i;
            uns_reg  <= bus.d_unsigned_i;
            wr_reg   <= bus.d_wr_i;
            if (req_err) begin
              state_reg   <= ST_RESP;
              d_ready_reg <= 1'b1;
              d_err_reg   <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state_reg   <= ST_RESP;
              d_ready_reg <= 1'b1;
            end else begin
              state_reg <= ST_WAIT;
              cnt_reg   <= 4'(WAIT_STATES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg   <= ST_RESP;
            d_ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          state_reg   <= ST_IDLE;
          d_ready_reg <= 1'b0;
          d_err_reg   <= 1'b0;
        end
        default: begin
          state_reg   <= ST_IDLE;
          d_ready_reg <= 1'b0;
          d_err_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.d_ready_o = d_ready_reg;
  assign bus.d_err_o   = d_err_reg;
  assign bus.d_data_o  = d_data_reg;
endmodule
